// File: rtl/credit_receiver_mc_pkg.sv
// rtl/credit_receiver_mc_pkg.sv - shared widths, credit return type and helpers
package credit_receiver_mc_pkg;

   // Widest channel id the shared credit-return record can carry.
   localparam int MaxIdWidth = 16;

   typedef struct packed {
      logic                  valid;
      logic [MaxIdWidth-1:0] id;
   } credit_return_t;

   // A single channel still needs a one-bit id field.
   function automatic int id_width(input int num_channels);
      return (num_channels > 1) ? $clog2(num_channels) : 1;
   endfunction

   // Counter must be able to hold MaxCredit itself.
   function automatic int count_width(input int max_credit);
      return $clog2(max_credit + 1);
   endfunction

   function automatic int pop_credit_width(input int pop_credit_max_change);
      return $clog2(pop_credit_max_change + 1);
   endfunction

   function automatic credit_return_t make_return(input logic valid,
                                                  input logic [MaxIdWidth-1:0] id);
      credit_return_t ret;
      ret.valid = valid;
      ret.id    = valid ? id : '0;
      return ret;
   endfunction

endpackage

// File: rtl/credit_receiver_mc_arbiter.sv
// rtl/credit_receiver_mc_arbiter.sv - round-robin arbiter for the shared credit-return wire
module credit_rr_arbiter
   import credit_receiver_mc_pkg::*;
#(
   parameter  int NumChannels = 4,
   localparam int IdWidth     = id_width(NumChannels)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NumChannels-1:0] i_req,
   input  logic                   i_advance,
   output logic [NumChannels-1:0] o_grant,
   output logic [IdWidth-1:0]     o_id
);

   logic [IdWidth-1:0] r_ptr;
   logic [IdWidth-1:0] w_ptr_next;
   logic               w_found;

   // Search upward from the pointer, wrapping, and grant the first requester.
   always_comb begin
      o_grant = '0;
      o_id    = '0;
      w_found = 1'b0;
      for (int k = 0; k < NumChannels; k++) begin
         if (!w_found && i_req[IdWidth'((int'(r_ptr) + k) % NumChannels)]) begin
            w_found = 1'b1;
            o_grant[IdWidth'((int'(r_ptr) + k) % NumChannels)] = 1'b1;
            o_id    = IdWidth'((int'(r_ptr) + k) % NumChannels);
         end
      end
   end

   // The channel after the winner gets first look next time.
   always_comb begin
      w_ptr_next = (o_id == IdWidth'(NumChannels - 1)) ? '0 : o_id + 1'b1;
   end

   // Pointer only moves on an actual grant, so it holds through stalls and reset of the sender.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_advance && w_found) begin
         r_ptr <= w_ptr_next;
      end
   end

endmodule

// File: rtl/credit_receiver_mc.sv
// rtl/credit_receiver_mc.sv - multi-channel credit receiver with round-robin credit return
module credit_receiver_mc
   import credit_receiver_mc_pkg::*;
#(
   parameter  int NumChannels        = 4,
   parameter  int DataWidth          = 8,
   parameter  int MaxCredit          = 8,
   parameter  int PopCreditMaxChange = 1,
   localparam int IdWidth            = id_width(NumChannels),
   localparam int CountWidth         = count_width(MaxCredit),
   localparam int PopCreditWidth     = pop_credit_width(PopCreditMaxChange)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                push_sender_in_reset,
   output logic                                push_receiver_in_reset,
   input  logic                                push_valid,
   input  logic [IdWidth-1:0]                  push_vc,
   input  logic [DataWidth-1:0]                push_data,
   input  logic                                push_credit_stall,
   output logic                                push_credit,
   output logic [IdWidth-1:0]                  push_credit_id,
   output logic                                pop_valid,
   output logic [IdWidth-1:0]                  pop_vc,
   output logic [DataWidth-1:0]                pop_data,
   input  logic [NumChannels*PopCreditWidth-1:0] pop_credit,
   input  logic [NumChannels*CountWidth-1:0]   credit_initial,
   input  logic [NumChannels*CountWidth-1:0]   credit_withhold,
   output logic [NumChannels*CountWidth-1:0]   credit_count,
   output logic [NumChannels-1:0]              credit_available,
   output logic [NumChannels-1:0]              credit_overflow
);

   logic                   w_in_reset;
   logic [NumChannels-1:0] w_eligible;
   logic [NumChannels-1:0] w_grant;
   logic [IdWidth-1:0]     w_arb_id;
   credit_return_t         w_ret;

   assign w_in_reset             = rst | push_sender_in_reset;
   assign push_receiver_in_reset = rst;

   // Flits pass straight through; only validity is masked while either side is in reset.
   assign pop_valid = push_valid & ~w_in_reset;
   assign pop_vc    = push_vc;
   assign pop_data  = push_data;

   // A channel may return a credit only from registered availability, never from this cycle's pop_credit.
   assign w_eligible = credit_available & {NumChannels{~push_credit_stall & ~w_in_reset}};

   credit_rr_arbiter #(
      .NumChannels(NumChannels)
   ) u_arbiter (
      .clk       (clk),
      .rst       (rst),
      .i_req     (w_eligible),
      .i_advance (|w_eligible),
      .o_grant   (w_grant),
      .o_id      (w_arb_id)
   );

   assign w_ret = make_return(|w_eligible, MaxIdWidth'(w_arb_id));

   // Drive the shared credit wire from the return record; id reads zero when nothing is returned.
   always_comb begin
      push_credit    = w_ret.valid;
      push_credit_id = '0;
      for (int c = 0; c < NumChannels; c++) begin
         if (w_ret.valid && (w_ret.id == MaxIdWidth'(c))) begin
            push_credit_id = IdWidth'(c);
         end
      end
   end

   for (genvar c = 0; c < NumChannels; c++) begin : g_chan
      logic [CountWidth-1:0]     r_count;
      logic                      r_overflow;
      logic [CountWidth:0]       w_next;
      logic [CountWidth-1:0]     w_initial;
      logic [CountWidth-1:0]     w_withhold;
      logic [PopCreditWidth-1:0] w_pop;

      assign w_initial  = credit_initial[c*CountWidth +: CountWidth];
      assign w_withhold = credit_withhold[c*CountWidth +: CountWidth];
      assign w_pop      = pop_credit[c*PopCreditWidth +: PopCreditWidth];

      // One extra bit so a replenish past the ceiling is visible before clamping.
      // A grant implies count > withhold >= 0, so the subtraction cannot wrap.
      assign w_next = {1'b0, r_count}
                    + (CountWidth+1)'(w_pop)
                    - (CountWidth+1)'(w_grant[c]);

      // Per-channel counter: reload while the sender is in reset, otherwise replenish minus grant, saturating.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
         end else if (push_sender_in_reset) begin
            if (w_initial > CountWidth'(MaxCredit)) begin
               r_count    <= CountWidth'(MaxCredit);
               r_overflow <= 1'b1;
            end else begin
               r_count <= w_initial;
            end
         end else if (w_next > (CountWidth+1)'(MaxCredit)) begin
            r_count    <= CountWidth'(MaxCredit);
            r_overflow <= 1'b1;
         end else begin
            r_count <= w_next[CountWidth-1:0];
         end
      end

      assign credit_count[c*CountWidth +: CountWidth] = r_count;
      assign credit_available[c]                      = r_count > w_withhold;
      assign credit_overflow[c]                       = r_overflow;
   end

endmodule

// File: tb/tb_credit_receiver_mc.sv
// tb/tb_credit_receiver_mc.sv - randomized self-checking bench for credit_receiver_mc
module tb_credit_receiver_mc;

   localparam int NC  = 4;
   localparam int DW  = 8;
   localparam int MC  = 8;
   localparam int PCM = 2;
   localparam int IW  = 2;
   localparam int CW  = 4;
   localparam int PW  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             push_sender_in_reset;
   logic             push_receiver_in_reset;
   logic             push_valid;
   logic [IW-1:0]    push_vc;
   logic [DW-1:0]    push_data;
   logic             push_credit_stall;
   logic             push_credit;
   logic [IW-1:0]    push_credit_id;
   logic             pop_valid;
   logic [IW-1:0]    pop_vc;
   logic [DW-1:0]    pop_data;
   logic [NC*PW-1:0] pop_credit;
   logic [NC*CW-1:0] credit_initial;
   logic [NC*CW-1:0] credit_withhold;
   logic [NC*CW-1:0] credit_count;
   logic [NC-1:0]    credit_available;
   logic [NC-1:0]    credit_overflow;

   credit_receiver_mc #(
      .NumChannels(NC), .DataWidth(DW), .MaxCredit(MC), .PopCreditMaxChange(PCM)
   ) dut (
      .clk(clk), .rst(rst),
      .push_sender_in_reset(push_sender_in_reset),
      .push_receiver_in_reset(push_receiver_in_reset),
      .push_valid(push_valid), .push_vc(push_vc), .push_data(push_data),
      .push_credit_stall(push_credit_stall),
      .push_credit(push_credit), .push_credit_id(push_credit_id),
      .pop_valid(pop_valid), .pop_vc(pop_vc), .pop_data(pop_data),
      .pop_credit(pop_credit), .credit_initial(credit_initial),
      .credit_withhold(credit_withhold), .credit_count(credit_count),
      .credit_available(credit_available), .credit_overflow(credit_overflow)
   );

   always #5 clk = ~clk;

   // Reference state: counters as plain integers, sticky flags, service pointer.
   int m_cnt[NC];
   bit m_ovf[NC];
   int m_ptr;

   int n_checks = 0;
   int n_errors = 0;

   // Values observed in the most recent step, for scenario-specific checks.
   logic          obs_credit;
   logic [IW-1:0] obs_id;
   logic          obs_pop_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wh(input int c);
      return int'(credit_withhold[c*CW +: CW]);
   endfunction

   // Winner among channels holding more credit than withheld, first from the pointer upward.
   function automatic int model_grant();
      if (rst || push_sender_in_reset || push_credit_stall) return -1;
      for (int k = 0; k < NC; k++) begin
         if (m_cnt[(m_ptr + k) % NC] > wh((m_ptr + k) % NC)) return (m_ptr + k) % NC;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NC; c++) begin
         m_cnt[c] = 0;
         m_ovf[c] = 1'b0;
      end
      m_ptr = 0;
   endfunction

   // One clock: compare all outputs mid-cycle, then advance the model across the edge.
   task automatic step();
      int g;
      int n;
      int ini;
      @(negedge clk);
      if (rst) model_reset();
      g = model_grant();
      obs_credit    = push_credit;
      obs_id        = push_credit_id;
      obs_pop_valid = pop_valid;
      check("push_credit", push_credit, (g >= 0) ? 1 : 0);
      check("push_credit_id", push_credit_id, (g >= 0) ? g : 0);
      check("pop_valid", pop_valid, push_valid && !(rst || push_sender_in_reset));
      check("pop_vc", pop_vc, push_vc);
      check("pop_data", pop_data, push_data);
      check("receiver_in_reset", push_receiver_in_reset, rst);
      for (int c = 0; c < NC; c++) begin
         check($sformatf("count%0d", c), credit_count[c*CW +: CW], m_cnt[c]);
         check($sformatf("available%0d", c), credit_available[c], (m_cnt[c] > wh(c)) ? 1 : 0);
         check($sformatf("overflow%0d", c), credit_overflow[c], m_ovf[c]);
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (push_sender_in_reset) begin
         for (int c = 0; c < NC; c++) begin
            ini = int'(credit_initial[c*CW +: CW]);
            if (ini > MC) begin
               m_cnt[c] = MC;
               m_ovf[c] = 1'b1;
            end else begin
               m_cnt[c] = ini;
            end
         end
      end else begin
         for (int c = 0; c < NC; c++) begin
            n = m_cnt[c] + int'(pop_credit[c*PW +: PW]) - ((g == c) ? 1 : 0);
            if (n > MC) begin
               n = MC;
               m_ovf[c] = 1'b1;
            end
            m_cnt[c] = n;
         end
         if (g >= 0) m_ptr = (g + 1) % NC;
      end
      #1;
   endtask

   // Force counters to known values through one sender-reset cycle.
   task automatic load(input int v0, input int v1, input int v2, input int v3);
      push_sender_in_reset = 1'b1;
      credit_initial = {CW'(v3), CW'(v2), CW'(v1), CW'(v0)};
      step();
      push_sender_in_reset = 1'b0;
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      push_sender_in_reset = 1'b0;
      push_valid = 1'b0;
      push_vc = '0;
      push_data = '0;
      push_credit_stall = 1'b0;
      pop_credit = '0;
      credit_initial = '0;
      credit_withhold = '0;

      // Reset, then reload {3,1,0,2} with the sender held in reset.
      step();
      step();
      check("rst_credit", obs_credit, 0);
      rst = 1'b0;
      push_sender_in_reset = 1'b1;
      credit_initial = {CW'(2), CW'(0), CW'(1), CW'(3)};
      step();
      check("reload_counts", credit_count, {CW'(2), CW'(0), CW'(1), CW'(3)});
      step();
      check("reload_no_credit", obs_credit, 0);

      // Round robin over four channels holding two credits each.
      load(2, 2, 2, 2);
      for (int i = 0; i < 8; i++) begin
         step();
         check("rr_credit", obs_credit, 1);
         check("rr_id", obs_id, i % NC);
      end
      step();
      check("rr_drained", obs_credit, 0);
      check("rr_counts", credit_count, 0);

      // Stall holds everything; release serves 0 then 1.
      load(1, 1, 0, 0);
      push_credit_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_credit", obs_credit, 0);
      end
      check("stall_counts", credit_count, {CW'(0), CW'(0), CW'(1), CW'(1)});
      push_credit_stall = 1'b0;
      step();
      check("stall_id0", obs_id, 0);
      step();
      check("stall_id1", obs_id, 1);

      // Withhold: channel 2 only returns what exceeds the withheld amount.
      credit_withhold = {CW'(0), CW'(3), CW'(0), CW'(0)};
      load(0, 0, 3, 0);
      step();
      check("wh_no_grant", obs_credit, 0);
      pop_credit = {PW'(0), PW'(2), PW'(0), PW'(0)};
      step();
      pop_credit = '0;
      check("wh_count5", credit_count[2*CW +: CW], 5);
      step();
      check("wh_id_a", obs_id, 2);
      check("wh_credit_a", obs_credit, 1);
      step();
      check("wh_id_b", obs_id, 2);
      step();
      check("wh_done", obs_credit, 0);
      check("wh_count3", credit_count[2*CW +: CW], 3);
      credit_withhold = '0;

      // Saturation sets a sticky flag that survives draining and reload.
      push_credit_stall = 1'b1;
      load(0, 7, 0, 0);
      pop_credit = {PW'(0), PW'(0), PW'(2), PW'(0)};
      step();
      pop_credit = '0;
      check("sat_count", credit_count[1*CW +: CW], MC);
      check("sat_flag", credit_overflow[1], 1);
      push_credit_stall = 1'b0;
      for (int i = 0; i < 10; i++) step();
      load(1, 0, 0, 0);
      check("sat_sticky", credit_overflow[1], 1);

      // Grant and replenish on the same channel cancel out.
      pop_credit = {PW'(0), PW'(0), PW'(0), PW'(1)};
      step();
      pop_credit = '0;
      check("net_grant", obs_credit, 1);
      check("net_count", credit_count[0 +: CW], 1);

      // Data forwarding and masking under sender reset.
      push_valid = 1'b1;
      push_vc = 2'd2;
      push_data = 8'hA5;
      step();
      check("data_valid", obs_pop_valid, 1);
      push_sender_in_reset = 1'b1;
      step();
      check("data_masked", obs_pop_valid, 0);
      push_sender_in_reset = 1'b0;

      // Randomized traffic against the reference model.
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         push_sender_in_reset = !rst && ($urandom_range(0, 29) == 0);
         push_credit_stall = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < NC; c++) begin
            pop_credit[c*PW +: PW] = ($urandom_range(0, 1) == 0) ? PW'($urandom_range(0, 2)) : '0;
            credit_initial[c*CW +: CW] = CW'($urandom_range(0, 10));
            if ($urandom_range(0, 15) == 0) credit_withhold[c*CW +: CW] = CW'($urandom_range(0, 3));
         end
         push_valid = 1'($urandom_range(0, 1));
         push_vc = IW'($urandom_range(0, NC - 1));
         push_data = DW'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/credit_receiver_mc.md
# credit_receiver_mc

Multi-channel, parametrised credit receiver for the receiving end of a credit-based link carrying several virtual channels. Per channel it holds a credit counter that is replenished by downstream pop-side credit returns. It returns credits to the sender over a single shared credit wire tagged with a channel ID, and forwards the push data stream to the pop side. It sits between the link input flops and the per-channel receive buffers. It adds the following behaviour:

- Per-channel counters
- Multi-credit returns per cycle
- Round-robin credit-return arbitration
- Saturation with sticky overflow flags

## Interface
Parameters:
- NumChannels, 4: virtual channels, ≥1; IdWidth = max(1, clog2(NumChannels)).
- DataWidth, 8: payload width.
- MaxCredit, 8: per-channel counter ceiling, ≥1; CountWidth = clog2(MaxCredit+1).
- PopCreditMaxChange, 1: maximum credits one channel returns per cycle; PopCreditWidth = clog2(PopCreditMaxChange+1).

Ports (reset is asynchronous, active-high; one clock):
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- push_sender_in_reset  in  1  sender is in reset; all counters reload.
- push_receiver_in_reset  out  1  equals rst (combinational).
- push_valid  in  1  flit valid from link.
- push_vc  in  IdWidth  channel of incoming flit.
- push_data  in  DataWidth  payload.
- push_credit_stall  in  1  sender cannot accept a credit this cycle.
- push_credit  out  1  one credit returned this cycle.
- push_credit_id  out  IdWidth  channel of the returned credit.
- pop_valid  out  1  forwarded flit valid.
- pop_vc  out  IdWidth  forwarded channel.
- pop_data  out  DataWidth  forwarded payload.
- pop_credit  in  NumChannels×PopCreditWidth  credits freed downstream, per channel.
- credit_initial  in  NumChannels×CountWidth  reload value per channel.
- credit_withhold  in  NumChannels×CountWidth  credits held back per channel.
- credit_count  out  NumChannels×CountWidth  current counters.
- credit_available  out  NumChannels  per-channel count > withhold.
- credit_overflow  out  NumChannels  sticky saturation flags.

## Operation
- in_reset = rst | push_sender_in_reset.
- Datapath is combinational:
  - pop_valid = push_valid & ~in_reset.
  - pop_vc = push_vc, pop_data = push_data, both unmodified.
- credit_available[c] = credit_count[c] > credit_withhold[c]. It uses registered state only; pop_credit has no bypass into availability.
- Eligibility: eligible[c] = credit_available[c] & ~push_credit_stall & ~in_reset.
- Arbitration:
  - Round-robin among eligible channels, searching upward from a priority pointer.
  - At most one grant per cycle.
  - push_credit = any eligible.
  - push_credit_id = granted channel, or 0 when push_credit=0.
- Pointer update:
  - On a grant, the pointer becomes (granted+1) mod NumChannels.
  - Otherwise the pointer holds, including while in_reset.
- Counter update when in_reset=0: next = count + pop_credit[c] − (grant to c ? 1 : 0), computed at CountWidth+1 bits.
  - If next > MaxCredit, the counter saturates at MaxCredit and credit_overflow[c] sets.
  - A simultaneous pop_credit and grant on the same channel net out.
- push_sender_in_reset=1 with rst=0:
  - Each cycle every counter loads credit_initial[c]; pop_credit is ignored.
  - credit_initial > MaxCredit clamps to MaxCredit and sets credit_overflow[c].
- credit_overflow is cleared only by rst.

## Timing
- Reset values under rst: credit_count=0, credit_overflow=0, pointer=0, push_credit=0, push_credit_id=0, pop_valid=0.
- push_receiver_in_reset=1 and credit_available=0, since 0 > withhold is false.
- Reload: credit_count equals credit_initial the first edge after rst deasserts while push_sender_in_reset=1.
- pop_credit → push_credit latency: 1 cycle minimum. The counter updates at edge N, availability rises in cycle N+1, and the grant can occur in cycle N+1.
- Throughput: one credit return per cycle across all channels. Any channel with credit is served within NumChannels cycles while stall=0.
- Mid-operation push_sender_in_reset:
  - push_credit and pop_valid drop the same cycle.
  - Counters reload at the next edge.
- Mid-operation rst: async clear of all state.

## Structure
- Shared package: localparam helpers for IdWidth, CountWidth and PopCreditWidth (clog2 wrappers), and a credit_return_t struct {valid, id}.
- One sub-module, credit_rr_arbiter:
  - Parameters: NumChannels.
  - Inputs: request vector, advance.
  - Outputs: one-hot grant and encoded id.
  - Internal pointer with async reset.
- The top level holds a generate loop of per-channel counters, the datapath and the output mux.

## Test plan
Configuration for all scenarios: NumChannels=4, MaxCredit=8, PopCreditMaxChange=2.
- Reset/reload:
  - Stimulus: rst=1, then rst=0 with sender_in_reset=1 and credit_initial={3,1,0,2}.
  - Response: counts 0 and push_credit=0 during rst. counts={3,1,0,2} one edge after release, and no push_credit while sender_in_reset=1.
- Round robin:
  - Stimulus: all counts 2, withhold 0, stall 0.
  - Response: push_credit_id sequence 0,1,2,3,0,1,2,3, then push_credit=0 and all counts 0.
- Stall:
  - Stimulus: counts {1,1,0,0}, stall=1 for 3 cycles.
  - Response: push_credit=0 and counts unchanged. After release the ids are 0 then 1.
- Withhold:
  - Stimulus: count[2]=3, withhold[2]=3, pop_credit[2]=2 for one cycle.
  - Response: no grant before. count[2]=5 the next cycle, then ids 2,2 and count[2] returns to 3.
- Saturation:
  - Stimulus: count[1]=7, stall=1, pop_credit[1]=2.
  - Response: count[1]=8 and credit_overflow[1]=1, which stays set until rst.
- Simultaneous and data:
  - Stimulus: count[0]=1 granted in the same cycle as pop_credit[0]=1.
  - Response: count[0] stays 1.
  - Stimulus: push_valid=1, push_vc=2, push_data=0xA5.
  - Response: pop_valid=1, pop_vc=2, pop_data=0xA5 in the same cycle; pop_valid=0 under sender_in_reset.
